// File: rtl/dly_cal_pkg.sv
// Shared types and constants for the coarse delay-line calibration controller.
package dly_cal_pkg;

    localparam int unsigned SEL_W = 3;
    localparam logic [SEL_W-1:0] SEL_MAX = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        ADJUST,
        DONE
    } cal_state_e;

    localparam logic DIR_DN = 1'b0;
    localparam logic DIR_UP = 1'b1;

endpackage

// File: rtl/dly_pd_vote.sv
// Counts phase-detector samples over one vote window and reports the majority.
module dly_pd_vote #(
    parameter int unsigned NSAMP = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic pd_up,
    output logic done_c,
    output logic vote_up_c
);

    localparam int unsigned CNT_W = $clog2(NSAMP + 1);
    localparam int unsigned CMP_W = CNT_W + 1;

    logic [CNT_W-1:0] samp_cnt;
    logic [CNT_W-1:0] vote_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            samp_cnt <= CNT_W'(NSAMP);
            vote_cnt <= '0;
        end else if (en) begin
            samp_cnt <= samp_cnt - CNT_W'(1);
            vote_cnt <= vote_cnt + CNT_W'(pd_up);
        end
    end

    // Last sample is being taken this cycle; the tally is final one cycle later.
    assign done_c    = en && (samp_cnt == CNT_W'(1));
    // Strict majority of up votes; a tie resolves as down.
    assign vote_up_c = {vote_cnt, 1'b0} > CMP_W'(NSAMP);

endmodule

// File: rtl/dly_coarse_cal_ctrl.sv
// Coarse delay-line calibration: steps the tap select from a start tap until the
// phase detector reverses (lock) or the select saturates (error).
module dly_coarse_cal_ctrl
    import dly_cal_pkg::*;
#(
    parameter int unsigned SEL_INIT   = 3,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned NSAMP      = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_pd_up,
    input  logic             i_man_en,
    input  logic [SEL_W-1:0] i_man_sel,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_busy,
    output logic             o_lock,
    output logic             o_err
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);

    cal_state_e       state;
    cal_state_e       state_nxt;
    logic [SET_W-1:0] settle_cnt;
    logic [SET_W-1:0] settle_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic             busy_nxt;
    logic             lock_nxt;
    logic             err_nxt;
    logic             dir;
    logic             dir_nxt;
    logic             dir_vld;
    logic             dir_vld_nxt;
    logic             vote_clr_c;
    logic             vote_en_c;
    logic             vote_done_c;
    logic             vote_up_c;
    logic             reverse_c;
    logic             sat_c;

    dly_pd_vote #(
        .NSAMP (NSAMP)
    ) u_vote (
        .clk       (i_clk),
        .rst       (i_rst),
        .clr       (vote_clr_c),
        .en        (vote_en_c),
        .pd_up     (i_pd_up),
        .done_c    (vote_done_c),
        .vote_up_c (vote_up_c)
    );

    assign reverse_c = dir_vld && (vote_up_c != dir);
    assign sat_c     = vote_up_c ? (o_sel == SEL_MAX) : (o_sel == '0);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (i_man_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (i_start) state_nxt = SETTLE;
                SETTLE:     if (settle_cnt == '0) state_nxt = SAMPLE;
                SAMPLE:     if (vote_done_c) state_nxt = ADJUST;
                ADJUST:     state_nxt = (reverse_c || sat_c) ? DONE : SETTLE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    // Output and datapath next values
    always_comb begin
        sel_nxt     = o_sel;
        busy_nxt    = o_busy;
        lock_nxt    = o_lock;
        err_nxt     = o_err;
        settle_nxt  = settle_cnt;
        dir_nxt     = dir;
        dir_vld_nxt = dir_vld;
        vote_clr_c  = 1'b0;
        vote_en_c   = 1'b0;
        if (i_man_en) begin
            sel_nxt     = i_man_sel;
            busy_nxt    = 1'b0;
            lock_nxt    = 1'b0;
            err_nxt     = 1'b0;
            dir_vld_nxt = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        sel_nxt     = SEL_W'(SEL_INIT);
                        lock_nxt    = 1'b0;
                        err_nxt     = 1'b0;
                        dir_vld_nxt = 1'b0;
                        settle_nxt  = SET_W'(SETTLE_CYC - 1);
                        busy_nxt    = 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        vote_clr_c = 1'b1;
                    end else begin
                        settle_nxt = settle_cnt - SET_W'(1);
                    end
                end
                SAMPLE: vote_en_c = 1'b1;
                ADJUST: begin
                    if (reverse_c) begin
                        lock_nxt = 1'b1;
                        busy_nxt = 1'b0;
                    end else if (sat_c) begin
                        err_nxt  = 1'b1;
                        busy_nxt = 1'b0;
                    end else begin
                        sel_nxt     = vote_up_c ? (o_sel + SEL_W'(1)) : (o_sel - SEL_W'(1));
                        dir_nxt     = vote_up_c ? DIR_UP : DIR_DN;
                        dir_vld_nxt = 1'b1;
                        settle_nxt  = SET_W'(SETTLE_CYC - 1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_sel      <= SEL_W'(SEL_INIT);
            o_busy     <= 1'b0;
            o_lock     <= 1'b0;
            o_err      <= 1'b0;
            settle_cnt <= '0;
            dir        <= DIR_DN;
            dir_vld    <= 1'b0;
        end else begin
            o_sel      <= sel_nxt;
            o_busy     <= busy_nxt;
            o_lock     <= lock_nxt;
            o_err      <= err_nxt;
            settle_cnt <= settle_nxt;
            dir        <= dir_nxt;
            dir_vld    <= dir_vld_nxt;
        end
    end

endmodule

// File: tb/tb_dly_coarse_cal_ctrl.sv
// Bench for dly_coarse_cal_ctrl: fixed vote-pattern table, random runs against an
// iteration-level model, and hand-written abort/override sequences.
module tb_dly_coarse_cal_ctrl;

    localparam int SETTLE = 8;
    localparam int NS     = 4;
    localparam int ITER   = SETTLE + NS + 1;
    localparam int SEL0   = 3;
    localparam int TMAX   = 200;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_pd_up = 1'b0;
    logic       i_man_en = 1'b0;
    logic [2:0] i_man_sel = 3'd0;
    logic [2:0] o_sel;
    logic       o_busy;
    logic       o_lock;
    logic       o_err;

    int checks = 0;
    int errors = 0;

    logic pd_hist [TMAX+1];
    int   sel_hist[TMAX+1];

    dly_coarse_cal_ctrl dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_pd_up   (i_pd_up),
        .i_man_en  (i_man_en),
        .i_man_sel (i_man_sel),
        .o_sel     (o_sel),
        .o_busy    (o_busy),
        .o_lock    (o_lock),
        .o_err     (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int         mode;   // 0: fixed window pattern, 1: pd_up = (o_sel < thr)
        logic [3:0] pat;    // bit j is the j-th sample of every vote window
        int         thr;
        int         e_sel;
        int         e_lock;
        int         e_err;
        int         e_cyc;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Start a calibration and drive i_pd_up until o_busy drops; returns busy length.
    task automatic run_cal(input int mode, input logic [3:0] pat, input int thr,
                           input string tag, output int cyc);
        int m;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk({tag, " start_sel"}, o_sel, SEL0);
        chk({tag, " start_busy"}, o_busy, 1);
        chk({tag, " start_flags"}, {o_lock, o_err}, 0);
        sel_hist[0] = o_sel;
        cyc = -1;
        for (int t = 0; t < TMAX; t++) begin
            m = t % ITER;
            case (mode)
                0:       i_pd_up = (m >= SETTLE && m < SETTLE + NS) ? pat[m-SETTLE] : 1'($urandom);
                1:       i_pd_up = (int'(o_sel) < thr);
                default: i_pd_up = ($urandom_range(99) < thr);
            endcase
            pd_hist[t] = i_pd_up;
            tick();
            sel_hist[t+1] = o_sel;
            if (!o_busy) begin
                cyc = t + 1;
                break;
            end
        end
        if (cyc < 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout busy still %0d after %0d cycles", tag, o_busy, TMAX);
        end
    endtask

    // Iteration-level reference: tally each vote window from the recorded samples.
    task automatic model_check(input string tag, input int cyc);
        int sel, dvld, d, lock, err, ecyc, votes, up;
        sel = SEL0; dvld = 0; d = 0; lock = 0; err = 0; ecyc = 0;
        for (int k = 0; k < 9 && lock == 0 && err == 0; k++) begin
            votes = 0;
            for (int j = 0; j < NS; j++) votes += int'(pd_hist[k*ITER + SETTLE + j]);
            up = (2 * votes > NS) ? 1 : 0;
            if (dvld != 0 && up != d) begin
                lock = 1;
            end else if ((up == 1 && sel == 7) || (up == 0 && sel == 0)) begin
                err = 1;
            end else begin
                sel = (up == 1) ? sel + 1 : sel - 1;
                d = up;
                dvld = 1;
                if ((k + 1) * ITER <= cyc) chk({tag, " trace_sel"}, sel_hist[(k+1)*ITER], sel);
            end
            ecyc = (k + 1) * ITER;
        end
        chk({tag, " sel"}, o_sel, sel);
        chk({tag, " lock"}, o_lock, lock);
        chk({tag, " err"}, o_err, err);
        chk({tag, " busy_len"}, cyc, ecyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs[0]  = '{0, 4'b1111, 0, 7, 0, 1, 65};
        vecs[1]  = '{1, 4'b0000, 5, 5, 1, 0, 39};
        vecs[2]  = '{0, 4'b0000, 0, 0, 0, 1, 52};
        vecs[3]  = '{0, 4'b0011, 0, 0, 0, 1, 52};   // 1,1,0,0 tie
        vecs[4]  = '{0, 4'b0111, 0, 7, 0, 1, 65};   // 1,1,1,0
        vecs[5]  = '{1, 4'b0000, 4, 4, 1, 0, 26};
        vecs[6]  = '{1, 4'b0000, 3, 2, 1, 0, 26};
        vecs[7]  = '{1, 4'b0000, 1, 0, 1, 0, 52};   // lock at tap 0, not error
        vecs[8]  = '{1, 4'b0000, 7, 7, 1, 0, 65};   // lock at tap 7, not error
        vecs[9]  = '{0, 4'b0001, 0, 0, 0, 1, 52};   // 1,0,0,0
        vecs[10] = '{0, 4'b1110, 0, 7, 0, 1, 65};   // 0,1,1,1

        repeat (2) tick();
        i_rst = 1'b0;
        chk("reset sel", o_sel, SEL0);
        chk("reset flags", {o_busy, o_lock, o_err}, 0);
        repeat (3) tick();
        chk("idle no_start busy", o_busy, 0);

        for (int i = 0; i < 11; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_cal(vecs[i].mode, vecs[i].pat, vecs[i].thr, tag, cyc);
            chk({tag, " sel"}, o_sel, vecs[i].e_sel);
            chk({tag, " lock"}, o_lock, vecs[i].e_lock);
            chk({tag, " err"}, o_err, vecs[i].e_err);
            chk({tag, " busy_len"}, cyc, vecs[i].e_cyc);
            tick();
            chk({tag, " hold_flags"}, {o_busy, o_lock, o_err}, {1'b0, 1'(vecs[i].e_lock), 1'(vecs[i].e_err)});
        end

        for (int r = 0; r < 15; r++) begin
            string tag;
            tag = $sformatf("rnd%0d", r);
            run_cal(2, 4'b0000, $urandom_range(100), tag, cyc);
            model_check(tag, cyc);
        end

        // Restart pulse mid-settle is ignored, then manual override aborts
        i_pd_up = 1'b1;
        i_start = 1'b1; tick(); i_start = 1'b0;
        repeat (3) tick();
        i_start = 1'b1; tick(); i_start = 1'b0;
        chk("restart busy", o_busy, 1);
        chk("restart sel", o_sel, SEL0);
        repeat (9) tick();
        chk("restart first_step_sel", o_sel, 4);
        repeat (7) tick();
        i_man_en = 1'b1; i_man_sel = 3'd6; tick();
        chk("man sel", o_sel, 6);
        chk("man flags", {o_busy, o_lock, o_err}, 0);
        i_man_sel = 3'd2; tick();
        chk("man follow sel", o_sel, 2);
        i_man_sel = 3'd6; i_start = 1'b1; tick(); i_start = 1'b0;
        chk("man beats start busy", o_busy, 0);
        i_man_en = 1'b0; i_man_sel = 3'd1;
        repeat (3) tick();
        chk("man hold sel", o_sel, 6);
        chk("man hold busy", o_busy, 0);
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        chk("rst sel", o_sel, SEL0);
        chk("rst flags", {o_busy, o_lock, o_err}, 0);

        // Reset mid-calibration leaves no residue
        i_start = 1'b1; tick(); i_start = 1'b0;
        repeat (20) tick();
        chk("mid sel before rst", o_sel, 4);
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        repeat (30) tick();
        chk("mid rst sel", o_sel, SEL0);
        chk("mid rst flags", {o_busy, o_lock, o_err}, 0);

        // Manual override clears a held error
        run_cal(0, 4'b1111, 0, "err_clr", cyc);
        chk("err_clr err set", o_err, 1);
        i_man_en = 1'b1; i_man_sel = 3'd5; tick(); i_man_en = 1'b0;
        chk("err_clr flags", {o_busy, o_lock, o_err}, 0);
        chk("err_clr sel", o_sel, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
